pcie_dma_tlp_requester: RTL and testbench

Outbound (initiator) side of the PCIe DMA endpoint. Takes single-beat 64-bit memory requests from the system bus side, emits MRd/MWr TLPs on the 64-bit TX stream, and parses the CplD/Cpl that returns on the RX stream. It returns read data and an AXI-style response code. One outstanding request at a time.

---
 rtl/pcie_dma_tlp_requester.sv | 252 +++++++++++++++++++++++++
 tb/tb_pcie_dma_tlp_requester.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_dma_tlp_requester.sv
// PCIe DMA requester: one single-beat bus request at a time becomes an MRd/MWr TLP,
// and the matching Cpl/CplD is parsed back into a bus response.
module pcie_dma_tlp_requester #(
    parameter int CPL_TIMEOUT = 4095
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_bus_master_en,
    input  logic [15:0] i_requester_id,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [47:0] i_req_addr,
    input  logic [63:0] i_req_wdata,
    input  logic [7:0]  i_req_wstrb,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [63:0] o_resp_rdata,
    output logic [1:0]  o_resp_err,
    output logic        o_txd_valid,
    input  logic        i_txd_ready,
    output logic [63:0] o_txd_data,
    output logic [7:0]  o_txd_keep,
    output logic        o_txd_last,
    input  logic        i_rxd_valid,
    output logic        o_rxd_ready,
    input  logic [63:0] i_rxd_data,
    input  logic        i_rxd_last
);
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HDR0     = 4'd1;
    localparam logic [3:0] S_HDR1     = 4'd2;
    localparam logic [3:0] S_PAYLOAD  = 4'd3;
    localparam logic [3:0] S_WAIT_CPL = 4'd4;
    localparam logic [3:0] S_CPL_DW2  = 4'd5;
    localparam logic [3:0] S_CPL_DATA = 4'd6;
    localparam logic [3:0] S_DROP     = 4'd7;
    localparam logic [3:0] S_RESP     = 4'd8;

    localparam logic [1:0] OKAY   = 2'd0;
    localparam logic [1:0] SLVERR = 2'd2;
    localparam logic [1:0] DECERR = 2'd3;

    logic [3:0]  state, state_n;
    logic        req_wr, len2, cpl_has_data, drop_to_resp, rx_sop;
    logic        req_ready_q, rxd_ready_q;
    logic [47:0] addr_q;
    logic [31:0] pdw0, pdw1;
    logic [3:0]  first_be, last_be;
    logic [7:0]  tag, issued_tag;
    logic [15:0] cnt;
    logic [2:0]  cpl_status;
    logic [1:0]  resp_err;
    logic [63:0] resp_rdata;

    logic        accept, tx_fire, rx_fire, is4dw, lo_dw;
    logic        rx_type_ok, tag_hit, timeout_hit;
    logic [7:0]  strb_eff;
    logic [31:0] dw0, dw1, dw2, dw3;
    logic        unused_ok;

    function automatic logic [1:0] map_status(input logic [2:0] s);
        case (s)
            3'd0:    return OKAY;
            3'd1:    return DECERR;
            default: return SLVERR;
        endcase
    endfunction

    assign accept      = i_req_valid & req_ready_q;
    assign tx_fire     = o_txd_valid & i_txd_ready;
    assign rx_fire     = i_rxd_valid & rxd_ready_q;
    assign strb_eff    = (!i_req_write && i_req_wstrb == 8'h00) ? 8'hFF : i_req_wstrb;
    assign lo_dw       = |strb_eff[3:0];
    assign is4dw       = |addr_q[47:32];
    assign rx_type_ok  = (i_rxd_data[28:24] == 5'b01010);
    assign tag_hit     = (i_rxd_data[15:8] == issued_tag);
    assign timeout_hit = (cnt == 16'(CPL_TIMEOUT - 1));
    assign unused_ok   = ^i_req_addr[2:0];

    assign dw0 = {1'b0, req_wr, is4dw, 5'b00000, 14'd0, (len2 ? 10'd2 : 10'd1)};
    assign dw1 = {i_requester_id, tag, last_be, first_be};
    assign dw3 = {addr_q[31:2], 2'b00};
    assign dw2 = is4dw ? {16'h0000, addr_q[47:32]} : dw3;

    always_comb begin
        o_txd_valid = 1'b0;
        o_txd_data  = 64'h0;
        o_txd_keep  = 8'h00;
        o_txd_last  = 1'b0;
        case (state)
            S_HDR0: begin
                o_txd_valid = 1'b1;
                o_txd_data  = {dw1, dw0};
                o_txd_keep  = 8'hFF;
            end
            S_HDR1: begin
                o_txd_valid = 1'b1;
                if (is4dw) begin
                    o_txd_data = {dw3, dw2};
                    o_txd_keep = 8'hFF;
                    o_txd_last = !req_wr;
                end else if (req_wr) begin
                    o_txd_data = {pdw0, dw2};
                    o_txd_keep = 8'hFF;
                    o_txd_last = !len2;
                end else begin
                    o_txd_data = {32'h0, dw2};
                    o_txd_keep = 8'h0F;
                    o_txd_last = 1'b1;
                end
            end
            S_PAYLOAD: begin
                o_txd_valid = 1'b1;
                o_txd_last  = 1'b1;
                if (is4dw && len2) begin
                    o_txd_data = {pdw1, pdw0};
                    o_txd_keep = 8'hFF;
                end else begin
                    o_txd_data = {32'h0, is4dw ? pdw0 : pdw1};
                    o_txd_keep = 8'h0F;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:
                if (accept)
                    state_n = (!i_bus_master_en || (i_req_write && i_req_wstrb == 8'h00))
                              ? S_RESP : S_HDR0;
            S_HDR0:
                if (tx_fire) state_n = S_HDR1;
            S_HDR1:
                if (tx_fire)
                    state_n = !o_txd_last ? S_PAYLOAD : (req_wr ? S_RESP : S_WAIT_CPL);
            S_PAYLOAD:
                if (tx_fire) state_n = S_RESP;
            S_WAIT_CPL:
                if (rx_fire && rx_sop) begin
                    if (rx_type_ok) state_n = i_rxd_last ? S_RESP : S_CPL_DW2;
                    else            state_n = i_rxd_last ? S_WAIT_CPL : S_DROP;
                end else if (timeout_hit) begin
                    state_n = S_RESP;
                end
            S_CPL_DW2:
                if (rx_fire) begin
                    if (!tag_hit)
                        state_n = i_rxd_last ? S_WAIT_CPL : S_DROP;
                    else if (cpl_status == 3'd0 && cpl_has_data && len2 && !i_rxd_last)
                        state_n = S_CPL_DATA;
                    else
                        state_n = i_rxd_last ? S_RESP : S_DROP;
                end
            S_CPL_DATA:
                if (rx_fire) state_n = i_rxd_last ? S_RESP : S_DROP;
            S_DROP:
                if (rx_fire && i_rxd_last) state_n = drop_to_resp ? S_RESP : S_WAIT_CPL;
            S_RESP:
                if (i_resp_ready) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state        <= S_IDLE;
            req_ready_q  <= 1'b0;
            rxd_ready_q  <= 1'b0;
            req_wr       <= 1'b0;
            len2         <= 1'b0;
            addr_q       <= 48'h0;
            pdw0         <= 32'h0;
            pdw1         <= 32'h0;
            first_be     <= 4'h0;
            last_be      <= 4'h0;
            tag          <= 8'h00;
            issued_tag   <= 8'h00;
            cnt          <= 16'h0;
            cpl_status   <= 3'd0;
            cpl_has_data <= 1'b0;
            drop_to_resp <= 1'b0;
            rx_sop       <= 1'b1;
            resp_err     <= OKAY;
            resp_rdata   <= 64'h0;
        end else begin
            state       <= state_n;
            req_ready_q <= (state_n == S_IDLE);
            rxd_ready_q <= (state_n != S_RESP);
            if (rx_fire) rx_sop <= i_rxd_last;
            case (state)
                S_IDLE:
                    if (accept) begin
                        req_wr       <= i_req_write;
                        addr_q       <= {i_req_addr[47:3], ~lo_dw, 2'b00};
                        len2         <= lo_dw & (|strb_eff[7:4]);
                        first_be     <= lo_dw ? strb_eff[3:0] : strb_eff[7:4];
                        last_be      <= lo_dw ? strb_eff[7:4] : 4'h0;
                        pdw0         <= lo_dw ? i_req_wdata[31:0] : i_req_wdata[63:32];
                        pdw1         <= i_req_wdata[63:32];
                        cnt          <= 16'h0;
                        drop_to_resp <= 1'b0;
                        resp_err     <= i_bus_master_en ? OKAY : DECERR;
                        resp_rdata   <= 64'h0;
                    end
                S_HDR0:
                    if (tx_fire && !req_wr) begin
                        issued_tag <= tag;
                        tag        <= tag + 8'd1;
                    end
                S_WAIT_CPL: begin
                    cnt <= cnt + 16'd1;
                    if (rx_fire && rx_sop) begin
                        drop_to_resp <= 1'b0;
                        if (rx_type_ok) begin
                            cpl_status   <= i_rxd_data[47:45];
                            cpl_has_data <= i_rxd_data[30];
                            if (i_rxd_last) resp_err <= SLVERR;
                        end
                    end else if (timeout_hit) begin
                        resp_err <= SLVERR;
                    end
                end
                S_CPL_DW2:
                    if (rx_fire && tag_hit) begin
                        // remaining beats of a matched completion are drained, then we respond
                        drop_to_resp <= 1'b1;
                        if (cpl_status != 3'd0)
                            resp_err <= map_status(cpl_status);
                        else if (!cpl_has_data || (len2 && i_rxd_last))
                            resp_err <= SLVERR;
                        else
                            resp_rdata <= i_rxd_data[2] ? {i_rxd_data[63:32], 32'h0}
                                                        : {32'h0, i_rxd_data[63:32]};
                    end
                S_CPL_DATA:
                    if (rx_fire) resp_rdata[63:32] <= i_rxd_data[31:0];
                default: ;
            endcase
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_rxd_ready  = rxd_ready_q;
    assign o_resp_valid = (state == S_RESP);
    assign o_resp_rdata = resp_rdata;
    assign o_resp_err   = resp_err;

endmodule

// File: tb/tb_pcie_dma_tlp_requester.sv
// Directed bench for pcie_dma_tlp_requester: TLP encoding, completion parsing,
// timeout, early exits, TX back-pressure and mid-TLP reset.
module tb_pcie_dma_tlp_requester;
    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_bus_master_en = 1'b1;
    logic [15:0] i_requester_id = 16'hABCD;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic        i_req_write = 1'b0;
    logic [47:0] i_req_addr = '0;
    logic [63:0] i_req_wdata = '0;
    logic [7:0]  i_req_wstrb = '0;
    logic        o_resp_valid;
    logic        i_resp_ready = 1'b0;
    logic [63:0] o_resp_rdata;
    logic [1:0]  o_resp_err;
    logic        o_txd_valid;
    logic        i_txd_ready = 1'b1;
    logic [63:0] o_txd_data;
    logic [7:0]  o_txd_keep;
    logic        o_txd_last;
    logic        i_rxd_valid = 1'b0;
    logic        o_rxd_ready;
    logic [63:0] i_rxd_data = '0;
    logic        i_rxd_last = 1'b0;

    int checks = 0;
    int failures = 0;

    pcie_dma_tlp_requester #(.CPL_TIMEOUT(16)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_bus_master_en(i_bus_master_en),
        .i_requester_id(i_requester_id), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_write(i_req_write), .i_req_addr(i_req_addr), .i_req_wdata(i_req_wdata),
        .i_req_wstrb(i_req_wstrb), .o_resp_valid(o_resp_valid), .i_resp_ready(i_resp_ready),
        .o_resp_rdata(o_resp_rdata), .o_resp_err(o_resp_err), .o_txd_valid(o_txd_valid),
        .i_txd_ready(i_txd_ready), .o_txd_data(o_txd_data), .o_txd_keep(o_txd_keep),
        .o_txd_last(o_txd_last), .i_rxd_valid(i_rxd_valid), .o_rxd_ready(o_rxd_ready),
        .i_rxd_data(i_rxd_data), .i_rxd_last(i_rxd_last)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic request(input logic wr, input logic [47:0] addr,
                           input logic [63:0] wdata, input logic [7:0] strb);
        int n = 0;
        while (!o_req_ready && n < 40) begin tick(); n++; end
        chk("req_ready", o_req_ready, 1);
        i_req_valid = 1'b1; i_req_write = wr; i_req_addr = addr;
        i_req_wdata = wdata; i_req_wstrb = strb;
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic expect_beat(input string tag, input logic [63:0] data,
                               input logic [7:0] keep, input logic last);
        int n = 0;
        while (!o_txd_valid && n < 20) begin tick(); n++; end
        chk({tag, ".valid"}, o_txd_valid, 1);
        chk({tag, ".data"}, o_txd_data, data);
        chk({tag, ".keep"}, o_txd_keep, keep);
        chk({tag, ".last"}, o_txd_last, last);
        tick();
    endtask

    task automatic rx_beat(input logic [63:0] data, input logic last);
        int n = 0;
        i_rxd_valid = 1'b1; i_rxd_data = data; i_rxd_last = last;
        while (!o_rxd_ready && n < 40) begin tick(); n++; end
        chk("rxd_ready", o_rxd_ready, 1);
        tick();
        i_rxd_valid = 1'b0; i_rxd_last = 1'b0;
    endtask

    task automatic expect_resp(input string tag, input logic [1:0] err, input logic [63:0] rdata);
        int n = 0;
        while (!o_resp_valid && n < 60) begin tick(); n++; end
        chk({tag, ".valid"}, o_resp_valid, 1);
        chk({tag, ".err"}, o_resp_err, err);
        chk({tag, ".rdata"}, o_resp_rdata, rdata);
        i_resp_ready = 1'b1;
        tick();
        i_resp_ready = 1'b0;
    endtask

    initial begin
        #2;
        chk("rst.req_ready", o_req_ready, 0);
        chk("rst.txd_valid", o_txd_valid, 0);
        chk("rst.rxd_ready", o_rxd_ready, 0);
        chk("rst.resp_valid", o_resp_valid, 0);
        chk("rst.resp_err", o_resp_err, 0);
        tick(); tick();
        i_rst = 1'b0;
        tick();
        chk("post_rst.req_ready", o_req_ready, 1);
        chk("post_rst.rxd_ready", o_rxd_ready, 1);

        // 3DW MWr, one DW
        request(1'b1, 48'h0000_1000, 64'h11223344_55667788, 8'h0F);
        expect_beat("wr1.b0", 64'hABCD000F_40000001, 8'hFF, 1'b0);
        expect_beat("wr1.b1", 64'h55667788_00001000, 8'hFF, 1'b1);
        chk("wr1.posted", o_resp_valid, 1);
        expect_resp("wr1.resp", 2'd0, 64'h0);

        // 3DW MRd length 2, tag 0
        request(1'b0, 48'h0000_2000, 64'h0, 8'hFF);
        expect_beat("rd1.b0", 64'hABCD00FF_00000002, 8'hFF, 1'b0);
        expect_beat("rd1.b1", 64'h00000000_00002000, 8'h0F, 1'b1);
        rx_beat(64'h00000008_4A000002, 1'b0);
        rx_beat(64'hAABBCCDD_ABCD0000, 1'b0);
        rx_beat(64'h00000000_01020304, 1'b1);
        expect_resp("rd1.resp", 2'd0, 64'h01020304_AABBCCDD);

        // 4DW MRd, upper DW, tag 1; completion in the upper lane
        request(1'b0, 48'h1_0000_0004, 64'h0, 8'hF0);
        expect_beat("rd2.b0", 64'hABCD010F_20000001, 8'hFF, 1'b0);
        expect_beat("rd2.b1", 64'h00000004_00000001, 8'hFF, 1'b1);
        rx_beat(64'h00000004_4A000001, 1'b0);
        rx_beat(64'hDEADBEEF_ABCD0104, 1'b1);
        expect_resp("rd2.resp", 2'd0, 64'hDEADBEEF_00000000);

        // tag 2: wrong-tag completion and a non-completion TLP are dropped
        request(1'b0, 48'h0000_3000, 64'h0, 8'h0F);
        expect_beat("rd3.b0", 64'hABCD020F_00000001, 8'hFF, 1'b0);
        expect_beat("rd3.b1", 64'h00000000_00003000, 8'h0F, 1'b1);
        rx_beat(64'h00000004_4A000001, 1'b0);
        rx_beat(64'h12345678_ABCD0700, 1'b1);
        chk("rd3.mismatch_dropped", o_resp_valid, 0);
        rx_beat(64'h00000000_40000001, 1'b0);
        rx_beat(64'h99999999_00000000, 1'b1);
        chk("rd3.mwr_dropped", o_resp_valid, 0);
        rx_beat(64'h00000004_4A000001, 1'b0);
        rx_beat(64'h12345678_ABCD0200, 1'b1);
        expect_resp("rd3.resp", 2'd0, 64'h00000000_12345678);

        // tag 3: Cpl with UR status
        request(1'b0, 48'h0000_4000, 64'h0, 8'hFF);
        expect_beat("rd4.b0", 64'hABCD03FF_00000002, 8'hFF, 1'b0);
        expect_beat("rd4.b1", 64'h00000000_00004000, 8'h0F, 1'b1);
        rx_beat(64'h00002008_0A000000, 1'b0);
        rx_beat(64'h00000000_ABCD0300, 1'b1);
        expect_resp("rd4.resp", 2'd3, 64'h0);

        // tag 4: no completion, timeout after 16 cycles in WAIT_CPL
        request(1'b0, 48'h0000_5000, 64'h0, 8'h0F);
        expect_beat("rd5.b0", 64'hABCD040F_00000001, 8'hFF, 1'b0);
        expect_beat("rd5.b1", 64'h00000000_00005000, 8'h0F, 1'b1);
        for (int i = 0; i < 15; i++) tick();
        chk("rd5.before_timeout", o_resp_valid, 0);
        tick();
        chk("rd5.at_timeout", o_resp_valid, 1);
        expect_resp("rd5.resp", 2'd2, 64'h0);
        rx_beat(64'h00000004_4A000001, 1'b0);
        rx_beat(64'h55555555_ABCD0400, 1'b1);
        chk("rd5.late_silent", o_resp_valid, 0);
        chk("rd5.late_idle", o_req_ready, 1);

        // early exits: bus master disabled, write with no strobes
        i_bus_master_en = 1'b0;
        request(1'b1, 48'h0000_9000, 64'h1, 8'hFF);
        chk("bme.no_tx", o_txd_valid, 0);
        expect_resp("bme.resp", 2'd3, 64'h0);
        i_bus_master_en = 1'b1;
        request(1'b1, 48'h0000_9000, 64'h1, 8'h00);
        chk("nostrb.no_tx", o_txd_valid, 0);
        expect_resp("nostrb.resp", 2'd0, 64'h0);

        // 3DW MWr length 2 with a 5-cycle stall on beat1
        request(1'b1, 48'h0000_6000, 64'hCAFEF00D_12345678, 8'hFF);
        expect_beat("wr2.b0", 64'hABCD05FF_40000002, 8'hFF, 1'b0);
        i_txd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("wr2.stall_data", o_txd_data, 64'h12345678_00006000);
            tick();
        end
        i_txd_ready = 1'b1;
        expect_beat("wr2.b1", 64'h12345678_00006000, 8'hFF, 1'b0);
        expect_beat("wr2.b2", 64'h00000000_CAFEF00D, 8'h0F, 1'b1);
        expect_resp("wr2.resp", 2'd0, 64'h0);

        // reset while in HDR1 abandons the TLP and clears the tag
        request(1'b0, 48'h0000_7000, 64'h0, 8'h0F);
        expect_beat("rd6.b0", 64'hABCD050F_00000001, 8'hFF, 1'b0);
        i_txd_ready = 1'b0;
        i_rst = 1'b1;
        #1;
        chk("midrst.txd_valid", o_txd_valid, 0);
        chk("midrst.txd_data", o_txd_data, 64'h0);
        chk("midrst.req_ready", o_req_ready, 0);
        chk("midrst.rxd_ready", o_rxd_ready, 0);
        chk("midrst.resp_valid", o_resp_valid, 0);
        tick();
        i_rst = 1'b0;
        i_txd_ready = 1'b1;
        tick();
        chk("midrst.recover", o_req_ready, 1);
        request(1'b1, 48'h0000_8000, 64'h0, 8'h0F);
        expect_beat("wr3.b0", 64'hABCD000F_40000001, 8'hFF, 1'b0);
        expect_beat("wr3.b1", 64'h00000000_00008000, 8'hFF, 1'b1);
        expect_resp("wr3.resp", 2'd0, 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
